branch_resolve_unit: RTL

- EX-stage resolver. It compares each executed control-flow instruction's real outcome against the prediction carried down the pipe.
- It generates the registered predictor-update bundle (BTB, RAS and BTB/RAS chooser feedback), the mispredict flag and the front-end redirect.
- Source side of the npc predictor's update interface. Also owns the committed branch-history register and squashes wrong-path updates after a redirect.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bru_shadow_ctr.sv | 53 +++++
 rtl/branch_resolve_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: control-flow kind encodings,
// default widths and the resolver's IDLE/SHADOW state encoding.
package bp_pkg;

    localparam int ADDR_WIDTH_DEF = 30;
    localparam int BH_WIDTH_DEF   = 16;

    // Control-flow kinds carried down the pipe with each instruction.
    localparam logic [2:0] KIND_NOT_JUMP      = 3'd0;
    localparam logic [2:0] KIND_DIRECT_JUMP   = 3'd1;
    localparam logic [2:0] KIND_RET           = 3'd4;
    localparam logic [2:0] KIND_INDIRECT_JUMP = 3'd5;
    localparam logic [2:0] KIND_CALL          = 3'd6;
    localparam logic [2:0] KIND_JUMP          = 3'd7;

    // Resolver FSM states.
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_SHADOW = 1'b1;

endpackage

// File: rtl/bru_shadow_ctr.sv
// Wrong-path shadow tracker: after a redirect, EX results are ignored for
// SHADOW_CYCLES non-stalled cycles. Stalls freeze the countdown.
module bru_shadow_ctr
    import bp_pkg::*;
#(
    parameter int SHADOW_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic start,
    output logic idle
);

    logic       state;
    logic [2:0] count;

    // IDLE/SHADOW state and countdown; a start while shadowing is ignored.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= ST_IDLE;
            count <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SHADOW;
                        count <= 3'(SHADOW_CYCLES);
                    end
                end
                ST_SHADOW: begin
                    if (!stall) begin
                        if (count <= 3'd1) begin
                            state <= ST_IDLE;
                            count <= 3'd0;
                        end else begin
                            count <= count - 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= 3'd0;
                end
            endcase
        end
    end

    assign idle = (state == ST_IDLE);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: checks the real outcome of each control-flow
// instruction against its prediction, emits the registered predictor-update
// bundle, mispredict/flush pulses and the front-end redirect, and keeps the
// committed branch history.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int bh_width      = BH_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] pc_ex_i,
    input  logic [2:0]            kind_ex_i,
    input  logic                  cond_taken,
    input  logic [ADDR_WIDTH-1:0] target_ex,
    input  logic [ADDR_WIDTH-1:0] npc_pdc_ex,
    input  logic [ADDR_WIDTH-1:0] npc_btb_ex,
    input  logic [ADDR_WIDTH-1:0] npc_ras_ex,
    input  logic [bh_width-1:0]   bh_ex_i,
    input  logic [1:0]            choice_pdch_i,
    output logic                  update_en,
    output logic                  taken_ex,
    output logic [ADDR_WIDTH-1:0] npc_ex,
    output logic [ADDR_WIDTH-1:0] pc_ex,
    output logic [bh_width-1:0]   bh_ex,
    output logic [2:0]            kind_ex,
    output logic [1:0]            choice_pdch_ex,
    output logic                  choice_real,
    output logic [ADDR_WIDTH-1:0] ret_pc_ex,
    output logic                  mis_pdc,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [bh_width-1:0]   redirect_bh,
    output logic [bh_width-1:0]   bh_commit
);

    logic                  idle;
    logic                  sample;
    logic                  mispredict;
    logic                  is_direct;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] real_npc;
    logic [bh_width-1:0]   shifted_bh;

    // Real outcome of the EX instruction and whether the front end guessed it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        seq_pc     = pc_ex_i + ADDR_WIDTH'(1);
        real_npc   = seq_pc;
        if (cond_taken) real_npc = target_ex;
        mispredict = (real_npc != npc_pdc_ex);
        is_direct  = (kind_ex_i == KIND_DIRECT_JUMP);
        shifted_bh = {bh_ex_i[bh_width-2:0], cond_taken};
    end

    assign sample = ex_valid & ~stall & idle;

    bru_shadow_ctr #(
        .SHADOW_CYCLES(SHADOW_CYCLES)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .start (sample & mispredict),
        .idle  (idle)
    );

    // One-cycle pulses: high only in the cycle after a sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            update_en <= 1'b0;
            mis_pdc   <= 1'b0;
            flush     <= 1'b0;
        end else begin
            update_en <= sample;
            mis_pdc   <= sample & mispredict;
            flush     <= sample & mispredict;
        end
    end

    // Update bundle and redirect data: captured on sample, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_ex       <= 1'b0;
            npc_ex         <= '0;
            pc_ex          <= '0;
            bh_ex          <= '0;
            kind_ex        <= 3'd0;
            choice_pdch_ex <= 2'd0;
            choice_real    <= 1'b0;
            ret_pc_ex      <= '0;
            redirect_pc    <= '0;
            redirect_bh    <= '0;
        end else if (sample) begin
            taken_ex       <= cond_taken;
            npc_ex         <= real_npc;
            pc_ex          <= pc_ex_i;
            bh_ex          <= bh_ex_i;
            kind_ex        <= kind_ex_i;
            choice_pdch_ex <= choice_pdch_i;
            choice_real    <= (npc_ras_ex != real_npc);
            ret_pc_ex      <= seq_pc;
            redirect_pc    <= real_npc;
            redirect_bh    <= is_direct ? shifted_bh : bh_ex_i;
        end
    end

    // Committed history advances only on resolved conditional branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            bh_commit <= '0;
        end else if (sample && is_direct) begin
            bh_commit <= {bh_commit[bh_width-2:0], cond_taken};
        end
    end

    // The BTB candidate rides along for the predictor but is not needed here.
    logic unused_btb;
    assign unused_btb = ^npc_btb_ex;

endmodule
